// File: rtl/sump_pkg.sv
// Shared SUMP protocol definitions: opcodes, decoder states, trigger register selectors.
// Pure declarations; no timing or flow control of its own.
package sump_pkg;

  localparam logic [7:0] OPC_RESET    = 8'h00;
  localparam logic [7:0] OPC_RUN      = 8'h01;
  localparam logic [7:0] OPC_ID       = 8'h02;
  localparam logic [7:0] OPC_XON      = 8'h11;
  localparam logic [7:0] OPC_XOFF     = 8'h13;
  localparam logic [7:0] OPC_DIV      = 8'h80;
  localparam logic [7:0] OPC_CNT      = 8'h81;
  localparam logic [7:0] OPC_FLAGS    = 8'h82;
  localparam logic [7:0] OPC_TRG_BASE = 8'hC0;

  typedef enum logic {
    IDLE,
    ARG
  } dec_state_t;

  typedef enum logic [1:0] {
    TRG_MASK   = 2'd0,
    TRG_VALUE  = 2'd1,
    TRG_CONFIG = 2'd2
  } trg_reg_t;

  // Trigger opcodes 0xC0-0xCF address stage opc[3:2]; register slot 3 does not exist.
  function automatic logic is_long_opc(input logic [7:0] opc);
    if (opc == OPC_DIV || opc == OPC_CNT || opc == OPC_FLAGS)
      return 1'b1;
    return (opc[7:4] == OPC_TRG_BASE[7:4]) && (opc[1:0] <= TRG_CONFIG);
  endfunction

endpackage

// File: rtl/sump_cmd_dec_if.sv
// Byte input and decoded command outputs of the SUMP command decoder.
// master drives received bytes and consumes commands; slave is the decoder.
interface sump_cmd_dec_if;

  logic        rx_stb_i;
  logic [7:0]  rx_data_i;
  logic [31:0] cmd_o;
  logic [7:0]  opc_o;
  logic        exe_o;
  logic        soft_rst_o;
  logic        run_o;
  logic        id_o;
  logic        tx_pause_o;
  logic        set_div_o;
  logic        set_cnt_o;
  logic        set_flags_o;
  logic        set_trg_o;
  logic [1:0]  trg_stage_o;
  logic [1:0]  trg_reg_o;
  logic        err_o;

  modport master (
    output rx_stb_i, rx_data_i,
    input  cmd_o, opc_o, exe_o, soft_rst_o, run_o, id_o, tx_pause_o,
           set_div_o, set_cnt_o, set_flags_o, set_trg_o, trg_stage_o, trg_reg_o, err_o
  );

  modport slave (
    input  rx_stb_i, rx_data_i,
    output cmd_o, opc_o, exe_o, soft_rst_o, run_o, id_o, tx_pause_o,
           set_div_o, set_cnt_o, set_flags_o, set_trg_o, trg_stage_o, trg_reg_o, err_o
  );

endinterface

// File: rtl/sump_cmd_dec.sv
// SUMP command decoder: assembles short/long commands from UART bytes into one-cycle strobes.
// Latency 1 cycle from completing byte; never backpressures, one byte per cycle, timeout resync.
module sump_cmd_dec
  import sump_pkg::*;
#(
  parameter int TIMEOUT = 100000
) (
  input logic           clk_i,
  input logic           rst_i,
  sump_cmd_dec_if.slave bus
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  dec_state_t    state_q, state_d;
  logic [7:0]    opc_sh_q;
  logic [23:0]   arg_sh_q;
  logic [1:0]    idx_q;
  logic [TW-1:0] tmo_q;

  logic        short_cmd, last_arg, tmo_hit;
  logic [31:0] arg_full;

  logic        exe_q, soft_q, run_q, id_q, div_q, cnt_q, flg_q, trg_q, err_q, pause_q;
  logic        exe_d, soft_d, run_d, id_d, div_d, cnt_d, flg_d, trg_d, err_d, pause_d;
  logic [7:0]  opc_q, opc_d;
  logic [31:0] cmd_q, cmd_d;
  logic [1:0]  stage_q, stage_d, treg_q, treg_d;

  assign short_cmd = (state_q == IDLE) && bus.rx_stb_i && !bus.rx_data_i[7];
  assign last_arg  = (state_q == ARG) && bus.rx_stb_i && (idx_q == 2'd3);
  // A byte in the expiry cycle wins over the abort.
  assign tmo_hit   = (state_q == ARG) && !bus.rx_stb_i && (tmo_q == TMO_LAST);
  // Little-endian: the shadow shifts right so the first argument byte ends in [7:0].
  assign arg_full  = {bus.rx_data_i, arg_sh_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.rx_stb_i && bus.rx_data_i[7]) state_d = ARG;
      ARG:  if (last_arg || tmo_hit)              state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opc_sh_q <= '0;
      arg_sh_q <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
    end else if (state_q == IDLE) begin
      tmo_q <= '0;
      if (bus.rx_stb_i && bus.rx_data_i[7]) begin
        opc_sh_q <= bus.rx_data_i;
        arg_sh_q <= '0;
        idx_q    <= '0;
      end
    end else if (bus.rx_stb_i) begin
      arg_sh_q <= arg_full[31:8];
      idx_q    <= idx_q + 2'd1;
      tmo_q    <= '0;
    end else if (tmo_hit) begin
      arg_sh_q <= '0;
      tmo_q    <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  always_comb begin
    exe_d   = 1'b0;
    soft_d  = 1'b0;
    run_d   = 1'b0;
    id_d    = 1'b0;
    div_d   = 1'b0;
    cnt_d   = 1'b0;
    flg_d   = 1'b0;
    trg_d   = 1'b0;
    err_d   = 1'b0;
    pause_d = pause_q;
    opc_d   = opc_q;
    cmd_d   = cmd_q;
    stage_d = stage_q;
    treg_d  = treg_q;
    if (short_cmd) begin
      unique case (bus.rx_data_i)
        OPC_RESET: begin exe_d = 1'b1; soft_d = 1'b1; pause_d = 1'b0; opc_d = bus.rx_data_i; end
        OPC_RUN:   begin exe_d = 1'b1; run_d  = 1'b1; opc_d = bus.rx_data_i; end
        OPC_ID:    begin exe_d = 1'b1; id_d   = 1'b1; opc_d = bus.rx_data_i; end
        OPC_XON:   begin exe_d = 1'b1; pause_d = 1'b0; opc_d = bus.rx_data_i; end
        OPC_XOFF:  begin exe_d = 1'b1; pause_d = 1'b1; opc_d = bus.rx_data_i; end
        default:   err_d = 1'b1;
      endcase
    end else if (last_arg) begin
      if (is_long_opc(opc_sh_q)) begin
        exe_d = 1'b1;
        opc_d = opc_sh_q;
        cmd_d = arg_full;
        unique case (opc_sh_q)
          OPC_DIV:   div_d = 1'b1;
          OPC_CNT:   cnt_d = 1'b1;
          OPC_FLAGS: flg_d = 1'b1;
          default: begin
            trg_d   = 1'b1;
            stage_d = opc_sh_q[3:2];
            treg_d  = opc_sh_q[1:0];
          end
        endcase
      end else begin
        err_d = 1'b1;
      end
    end else if (tmo_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      {exe_q, soft_q, run_q, id_q, div_q, cnt_q, flg_q, trg_q, err_q, pause_q} <= '0;
      opc_q   <= '0;
      cmd_q   <= '0;
      stage_q <= '0;
      treg_q  <= '0;
    end else begin
      {exe_q, soft_q, run_q, id_q, div_q, cnt_q, flg_q, trg_q, err_q, pause_q} <=
        {exe_d, soft_d, run_d, id_d, div_d, cnt_d, flg_d, trg_d, err_d, pause_d};
      opc_q   <= opc_d;
      cmd_q   <= cmd_d;
      stage_q <= stage_d;
      treg_q  <= treg_d;
    end
  end

  assign bus.exe_o       = exe_q;
  assign bus.soft_rst_o  = soft_q;
  assign bus.run_o       = run_q;
  assign bus.id_o        = id_q;
  assign bus.set_div_o   = div_q;
  assign bus.set_cnt_o   = cnt_q;
  assign bus.set_flags_o = flg_q;
  assign bus.set_trg_o   = trg_q;
  assign bus.err_o       = err_q;
  assign bus.tx_pause_o  = pause_q;
  assign bus.opc_o       = opc_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.trg_stage_o = stage_q;
  assign bus.trg_reg_o   = treg_q;

endmodule

// File: tb/tb_sump_cmd_dec.sv
// Scoreboard bench for sump_cmd_dec: expected strobes queued at drive time, matched when observed.
module tb_sump_cmd_dec;

  localparam int TMO = 16;

  localparam logic [8:0] S_EXE  = 9'h100;
  localparam logic [8:0] S_SRST = 9'h080;
  localparam logic [8:0] S_RUN  = 9'h040;
  localparam logic [8:0] S_ID   = 9'h020;
  localparam logic [8:0] S_DIV  = 9'h010;
  localparam logic [8:0] S_CNT  = 9'h008;
  localparam logic [8:0] S_FLG  = 9'h004;
  localparam logic [8:0] S_TRG  = 9'h002;
  localparam logic [8:0] S_ERR  = 9'h001;

  typedef struct {
    logic [8:0]  stb;
    logic [7:0]  opc;
    logic [31:0] cmd;
    logic        pause;
    logic [1:0]  stage;
    logic [1:0]  rg;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [8:0] mon_s;

  sump_cmd_dec_if bus();

  sump_cmd_dec #(.TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [8:0] obs_stb();
    return {bus.exe_o, bus.soft_rst_o, bus.run_o, bus.id_o, bus.set_div_o,
            bus.set_cnt_o, bus.set_flags_o, bus.set_trg_o, bus.err_o};
  endfunction

  task automatic push(input logic [8:0] stb, input logic [7:0] opc, input logic [31:0] cmd,
                      input logic pause, input logic [1:0] stage, input logic [1:0] rg,
                      input int dly);
    exp_t e;
    e.stb = stb; e.opc = opc; e.cmd = cmd; e.pause = pause;
    e.stage = stage; e.rg = rg; e.cyc = cyc + dly;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_stb_i  = 1'b1;
    bus.rx_data_i = b;
    @(posedge clk);
    #1;
    bus.rx_stb_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stb"},   64'(obs_stb()),       64'h0);
    chk({tag, "_cmd"},   64'(bus.cmd_o),       64'h0);
    chk({tag, "_opc"},   64'(bus.opc_o),       64'h0);
    chk({tag, "_pause"}, 64'(bus.tx_pause_o),  64'h0);
    chk({tag, "_stage"}, 64'(bus.trg_stage_o), 64'h0);
    chk({tag, "_treg"},  64'(bus.trg_reg_o),   64'h0);
  endtask

  // Every strobe cycle must match the next queued expectation, on time.
  always @(negedge clk) begin
    if (!rst) begin
      mon_s = obs_stb();
      if (mon_s != 9'h0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 64'(mon_s), 64'h0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("strobes", 64'(mon_s),          64'(mon_e.stb));
          chk("cycle",   64'(cyc),            64'(mon_e.cyc));
          chk("opc",     64'(bus.opc_o),      64'(mon_e.opc));
          chk("cmd",     64'(bus.cmd_o),      64'(mon_e.cmd));
          chk("pause",   64'(bus.tx_pause_o), 64'(mon_e.pause));
          if ((mon_e.stb & S_TRG) != 9'h0) begin
            chk("trg_stage", 64'(bus.trg_stage_o), 64'(mon_e.stage));
            chk("trg_reg",   64'(bus.trg_reg_o),   64'(mon_e.rg));
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        mon_e = sb_q.pop_front();
        chk("missing_strobe", 64'h0, 64'(mon_e.stb));
      end
    end
  end

  initial begin
    bus.rx_stb_i  = 1'b0;
    bus.rx_data_i = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(1);

    // Back-to-back short commands
    push(S_EXE | S_RUN, 8'h01, 32'h0, 1'b0, 2'd0, 2'd0, 1);
    send(8'h01);
    push(S_EXE | S_ID,  8'h02, 32'h0, 1'b0, 2'd0, 2'd0, 1);
    send(8'h02);
    idle(3);

    // Set count; cmd_o must not show partial words
    send(8'h81); send(8'h03); send(8'h00); send(8'h07);
    chk("cnt_cmd_hold", 64'(bus.cmd_o), 64'h0);
    push(S_EXE | S_CNT, 8'h81, 32'h0007_0003, 1'b0, 2'd0, 2'd0, 1);
    send(8'h00);
    idle(2);

    // Trigger stage 1, value register
    send(8'hC5); send(8'hAA); send(8'hBB); send(8'hCC);
    push(S_EXE | S_TRG, 8'hC5, 32'hDDCC_BBAA, 1'b0, 2'd1, 2'd1, 1);
    send(8'hDD);
    idle(2);

    // Timeout abort, then resync
    send(8'h80);
    push(S_ERR, 8'hC5, 32'hDDCC_BBAA, 1'b0, 2'd0, 2'd0, 1 + TMO);
    send(8'h11);
    idle(TMO + 4);
    push(S_EXE | S_RUN, 8'h01, 32'hDDCC_BBAA, 1'b0, 2'd0, 2'd0, 1);
    send(8'h01);
    idle(2);

    // Byte arriving in the expiry cycle is accepted
    send(8'h80); send(8'h11);
    idle(TMO - 1);
    send(8'h22); send(8'h33);
    push(S_EXE | S_DIV, 8'h80, 32'h4433_2211, 1'b0, 2'd0, 2'd0, 1);
    send(8'h44);
    idle(2);

    // Unknown short and long opcodes
    push(S_ERR, 8'h80, 32'h4433_2211, 1'b0, 2'd0, 2'd0, 1);
    send(8'h05);
    send(8'h9F); send(8'hAA); send(8'hBB); send(8'hCC);
    push(S_ERR, 8'h80, 32'h4433_2211, 1'b0, 2'd0, 2'd0, 1);
    send(8'hDD);
    idle(1);

    // XOFF/XON and soft reset
    push(S_EXE, 8'h13, 32'h4433_2211, 1'b1, 2'd0, 2'd0, 1);
    send(8'h13);
    push(S_EXE, 8'h13, 32'h4433_2211, 1'b1, 2'd0, 2'd0, 1);
    send(8'h13);
    push(S_EXE, 8'h11, 32'h4433_2211, 1'b0, 2'd0, 2'd0, 1);
    send(8'h11);
    push(S_EXE, 8'h13, 32'h4433_2211, 1'b1, 2'd0, 2'd0, 1);
    send(8'h13);
    push(S_EXE | S_SRST, 8'h00, 32'h4433_2211, 1'b0, 2'd0, 2'd0, 1);
    send(8'h00);
    idle(2);
    chk("pause_after_srst", 64'(bus.tx_pause_o), 64'h0);

    // Reset in the middle of a long command
    push(S_EXE, 8'h13, 32'h4433_2211, 1'b1, 2'd0, 2'd0, 1);
    send(8'h13);
    send(8'h82); send(8'h01); send(8'h02);
    rst = 1'b1;
    #1;
    check_zero("midcmd_reset");
    idle(2);
    rst = 1'b0;
    idle(1);
    push(S_EXE | S_ID, 8'h02, 32'h0, 1'b0, 2'd0, 2'd0, 1);
    send(8'h02);
    idle(10);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
